// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memory-side blocks.
package mips_pkg;

  // Access size encodings on mem_size; 2'b11 is treated as a word.
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  // Default data memory size in bytes.
  localparam int unsigned DMEM_DEPTH_BYTES = 2048;

  typedef enum logic {DS_IDLE, DS_SEND} dump_state_e;

  // Half needs an even address, word (and 2'b11) needs a word-aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = offset[0];
      default: mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension for a big-endian word.
module dmem_load_align
  import mips_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] raw,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane; offset 0 is the most significant byte.
  always_comb begin
    byte_v = raw[31:24];
    case (offset)
      2'd0: byte_v = raw[31:24];
      2'd1: byte_v = raw[23:16];
      2'd2: byte_v = raw[15:8];
      default: byte_v = raw[7:0];
    endcase
    half_v = offset[1] ? raw[15:0] : raw[31:16];
  end

  // Extend the selected lane; misaligned accesses return zero.
  always_comb begin
    rdata = '0;
    if (!is_misaligned(size, offset)) begin
      case (size)
        MEM_B:   rdata = zext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        MEM_H:   rdata = zext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        default: rdata = raw;
      endcase
    end
  end

endmodule

// File: rtl/dmem.sv
// Byte-addressed big-endian data memory with a streaming dump port.
module dmem
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DMEM_DEPTH_BYTES,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] mem_rdata,
  output logic        mem_misalign,
  input  logic        dump_start,
  output logic        dump_busy,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [63:0] dump_data,
  output logic        dump_last
);

  logic [7:0] mem [DEPTH_BYTES];

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base;
  logic [31:0]       raw_word;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic              unused_addr;

  dump_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_nx;
  logic [63:0]       beat_nx;
  logic              last_nx;
  logic              busy_q;
  logic              valid_q;
  logic              last_q;
  logic [63:0]       data_q;

  // Upper address bits are ignored so the address wraps.
  assign addr        = mem_addr[ADDR_W-1:0];
  assign base        = {addr[ADDR_W-1:2], 2'b00};
  assign unused_addr = ^mem_addr[31:ADDR_W];

  assign raw_word = {mem[base], mem[base + ADDR_W'(1)], mem[base + ADDR_W'(2)],
                     mem[base + ADDR_W'(3)]};

  assign mem_misalign = is_misaligned(mem_size, addr[1:0]);

  dmem_load_align u_load_align (
    .offset (addr[1:0]),
    .size   (mem_size),
    .zext   (mem_unsigned),
    .raw    (raw_word),
    .rdata  (mem_rdata)
  );

  // Store byte enables (be[i] is offset i in the word) and replicated write data.
  always_comb begin
    be    = 4'b0000;
    wword = mem_wdata;
    case (mem_size)
      MEM_B: begin
        be    = 4'b0001 << addr[1:0];
        wword = {4{mem_wdata[7:0]}};
      end
      MEM_H: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{mem_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (mem_misalign) be = 4'b0000;
  end

  // Array write; contents are not touched by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem[base + ADDR_W'(i)] <= wword[31-8*i -: 8];
    end
  end

  // Next beat address and its 8 bytes, read before any same-edge store lands.
  always_comb begin
    ptr_nx  = (state_q == DS_IDLE) ? '0 : ptr_q + ADDR_W'(8);
    beat_nx = '0;
    for (int i = 0; i < 8; i++) begin
      beat_nx[63-8*i -: 8] = mem[ptr_nx + ADDR_W'(i)];
    end
    last_nx = (ptr_nx == ADDR_W'(DEPTH_BYTES - 8));
  end

  // Dump FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DS_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (dump_start) begin
            state_q <= DS_SEND;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            ptr_q   <= ptr_nx;
            data_q  <= beat_nx;
            last_q  <= last_nx;
          end
        end
        DS_SEND: begin
          if (valid_q && dump_ready) begin
            if (last_q) begin
              state_q <= DS_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              ptr_q  <= ptr_nx;
              data_q <= beat_nx;
              last_q <= last_nx;
            end
          end
        end
        default: state_q <= DS_IDLE;
      endcase
    end
  end

  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_last  = last_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem.
module tb_dmem;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_rdata;
  logic        mem_misalign;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_data;
  logic        dump_last;

  int checks = 0;
  int errors = 0;

  dmem dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_rdata    (mem_rdata),
    .mem_misalign (mem_misalign),
    .dump_start   (dump_start),
    .dump_busy    (dump_busy),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_data    (dump_data),
    .dump_last    (dump_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    mem_addr  = a;
    mem_wdata = d;
    mem_size  = sz;
    mem_we    = 1'b1;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    mem_we       = 1'b0;
    mem_addr     = a;
    mem_size     = sz;
    mem_unsigned = u;
    #1;
  endtask

  // Hand-computed beats after the preload stores below.
  function automatic logic [63:0] exp_beat(input int i);
    case (i)
      0:       return 64'h00000000_0BADC0DE;
      2:       return 64'h11223344_00000000;
      4:       return 64'h80008001_00000000;
      5:       return 64'hA5A50005_00000000;
      6:       return 64'h00000006_00000000;
      255:     return 64'h00000000_CAFEF00D;
      default: return 64'h0;
    endcase
  endfunction

  initial begin
    int n;
    rst          = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    mem_size     = MEM_W;
    mem_unsigned = 1'b0;
    dump_start   = 1'b0;
    dump_ready   = 1'b0;
    #1;
    chk("rst_busy", dump_busy, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_last", dump_last, 0);
    chk("rst_data", dump_data, 0);
    #2 rst = 1'b1;
    tick();

    for (int a = 0; a < 2048; a += 4) store(a, 32'h0, MEM_W);

    // Word store and narrower loads.
    store(32'h10, 32'h11223344, MEM_W);
    load(32'h10, MEM_W, 1'b0); chk("lw_10", mem_rdata, 32'h11223344);
    load(32'h11, MEM_B, 1'b1); chk("lbu_11", mem_rdata, 32'h00000022);
    load(32'h12, MEM_H, 1'b1); chk("lhu_12", mem_rdata, 32'h00003344);
    load(32'h13, MEM_B, 1'b0); chk("lb_13", mem_rdata, 32'h00000044);

    // Byte and half stores with extension.
    store(32'h20, 32'h00000080, MEM_B);
    load(32'h20, MEM_B, 1'b0); chk("lb_20", mem_rdata, 32'hFFFFFF80);
    load(32'h20, MEM_B, 1'b1); chk("lbu_20", mem_rdata, 32'h00000080);
    store(32'h22, 32'h00008001, MEM_H);
    load(32'h22, MEM_H, 1'b0); chk("lh_22", mem_rdata, 32'hFFFF8001);
    load(32'h22, MEM_H, 1'b1); chk("lhu_22", mem_rdata, 32'h00008001);
    load(32'h20, MEM_W, 1'b0); chk("lw_20", mem_rdata, 32'h80008001);
    load(32'h820, MEM_W, 1'b0); chk("lw_wrap", mem_rdata, 32'h80008001);

    // Misaligned accesses.
    load(32'h21, MEM_H, 1'b0); chk("mis_lh", mem_misalign, 1);
    load(32'h21, MEM_B, 1'b0); chk("mis_lb", mem_misalign, 0);
    mem_addr  = 32'h13;
    mem_wdata = 32'hDEADBEEF;
    mem_size  = MEM_W;
    mem_we    = 1'b1;
    #1;
    chk("mis_sw_flag", mem_misalign, 1);
    chk("mis_sw_rdata", mem_rdata, 0);
    tick();
    mem_we = 1'b0;
    load(32'h10, MEM_W, 1'b0); chk("lw_10_after_mis", mem_rdata, 32'h11223344);

    // Extra preload so individual beats are distinguishable.
    store(32'h04, 32'h0BADC0DE, MEM_W);
    store(32'h28, 32'hA5A50005, MEM_W);
    store(32'h30, 32'h00000006, MEM_W);
    store(32'h7FC, 32'hCAFEF00D, MEM_W);

    // Full dump with ready held high.
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("full_busy", dump_busy, 1);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("full_valid%0d", i), dump_valid, 1);
      chk($sformatf("full_data%0d", i), dump_data, exp_beat(i));
      chk($sformatf("full_last%0d", i), dump_last, (i == 255) ? 64'd1 : 64'd0);
      tick();
    end
    chk("full_end_busy", dump_busy, 0);
    chk("full_end_valid", dump_valid, 0);
    chk("full_end_last", dump_last, 0);

    // Backpressure at beat 5, with a dump_start pulse that must be ignored.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (5) tick();
    chk("bp_beat5", dump_data, exp_beat(5));
    dump_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      chk($sformatf("bp_hold_data%0d", k), dump_data, exp_beat(5));
      chk($sformatf("bp_hold_valid%0d", k), dump_valid, 1);
    end
    dump_ready = 1'b1;
    tick();
    chk("bp_beat6", dump_data, exp_beat(6));

    // Store on the same edge that captures beat 7: capture sees old bytes.
    store(32'h38, 32'h77777777, MEM_W);
    chk("same_edge_beat7", dump_data, 64'h0);
    load(32'h38, MEM_W, 1'b0); chk("lw_38", mem_rdata, 32'h77777777);

    // Reset mid-dump at beat 10.
    repeat (3) tick();
    chk("pre_rst_busy", dump_busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", dump_valid, 0);
    chk("mid_rst_busy", dump_busy, 0);
    chk("mid_rst_last", dump_last, 0);
    chk("mid_rst_data", dump_data, 0);
    rst = 1'b1;
    #1;
    load(32'h10, MEM_W, 1'b0); chk("lw_10_after_rst", mem_rdata, 32'h11223344);

    // Restart from ptr 0 and drain with a bound.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("restart_beat0", dump_data, exp_beat(0));
    chk("restart_last0", dump_last, 0);
    tick();
    chk("restart_beat1", dump_data, exp_beat(1));
    n = 0;
    while (dump_busy && n < 300) begin
      tick();
      n++;
    end
    chk("restart_drain_beats", n, 255);
    chk("restart_end_busy", dump_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
